// File: rtl/requant_output_packer.sv
// Collects per-channel int8 requantizer results, aligns the SA_N channels of each pixel
// through small FIFOs and writes one channels-last word per pixel to activation memory.
module requant_output_packer #(
  parameter int SA_N       = 4,
  parameter int MAX_N      = 16,
  parameter int N_BITS     = $clog2(MAX_N),
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic [ADDR_W-1:0]               row_stride,
  input  logic [2*N_BITS:0]               num_pixels,
  input  logic [SA_N-1:0]                 in_valid,
  input  logic [SA_N-1:0][N_BITS-1:0]     in_row,
  input  logic [SA_N-1:0][N_BITS-1:0]     in_col,
  input  logic [SA_N-1:0][7:0]            in_data,
  output logic                            mem_wr_en,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [8*SA_N-1:0]               mem_wdata,
  input  logic                            mem_ready,
  output logic                            busy,
  output logic                            done,
  output logic [SA_N-1:0]                 overflow,
  output logic                            mismatch
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 2*N_BITS + 8;
  localparam int CNT_W = 2*N_BITS + 1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  function automatic logic [ADDR_W-1:0] calc_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] stride,
                                                  input logic [N_BITS-1:0] row,
                                                  input logic [N_BITS-1:0] col);
    calc_addr = base + stride * ADDR_W'(row) + ADDR_W'(col);
  endfunction

  logic [ADDR_W-1:0] base_q, stride_q;
  logic [CNT_W-1:0]  npix_q, count_q, loaded_q;

  // p0: per-channel FIFOs holding {row, col, data}
  logic [ENT_W-1:0] fifo_p0 [SA_N][FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr [SA_N];
  logic [PTR_W:0]   rd_ptr [SA_N];
  logic [ENT_W-1:0] head_p0 [SA_N];
  logic [SA_N-1:0]  empty, full, push_ok, push_drop;

  // p1: output word register, valid doubles as the write request
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [8*SA_N-1:0] wdata_p1;

  logic              pop, acc, fin, mis_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [8*SA_N-1:0] wdata_nxt;

  assign acc = vld_p1 && mem_ready;

  always_comb begin
    for (int ch = 0; ch < SA_N; ch++) begin
      empty[ch]   = (wr_ptr[ch] == rd_ptr[ch]);
      full[ch]    = ((wr_ptr[ch] - rd_ptr[ch]) == (PTR_W+1)'(FIFO_DEPTH));
      head_p0[ch] = fifo_p0[ch][rd_ptr[ch][PTR_W-1:0]];
    end
  end

  // Pops stop once every word of the tile has been loaded, so leftovers stay queued.
  assign pop = (state == RUN) && (&(~empty)) && (!vld_p1 || mem_ready) && (loaded_q < npix_q);

  always_comb begin
    for (int ch = 0; ch < SA_N; ch++) begin
      push_ok[ch]   = (state == RUN) && in_valid[ch] && (!full[ch] || pop);
      push_drop[ch] = (state == RUN) && in_valid[ch] && full[ch] && !pop;
    end
  end

  always_comb begin
    wdata_nxt = '0;
    mis_nxt   = 1'b0;
    for (int ch = 0; ch < SA_N; ch++) begin
      wdata_nxt[8*ch +: 8] = head_p0[ch][7:0];
      if (head_p0[ch][ENT_W-1:8] != head_p0[0][ENT_W-1:8]) mis_nxt = 1'b1;
    end
    addr_nxt = calc_addr(base_q, stride_q, head_p0[0][8+N_BITS +: N_BITS], head_p0[0][8 +: N_BITS]);
  end

  assign fin = (state == RUN) &&
               ((count_q == npix_q && !vld_p1) || (acc && (count_q + CNT_W'(1)) == npix_q));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (fin)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count_q  <= '0;
      loaded_q <= '0;
      overflow <= '0;
      mismatch <= 1'b0;
      done     <= 1'b0;
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      for (int ch = 0; ch < SA_N; ch++) begin
        wr_ptr[ch] <= '0;
        rd_ptr[ch] <= '0;
      end
    end else begin
      state <= state_nxt;
      done  <= fin;
      if (state == IDLE && start) begin
        count_q  <= '0;
        loaded_q <= '0;
        overflow <= '0;
        mismatch <= 1'b0;
      end else begin
        if (acc) count_q  <= count_q + CNT_W'(1);
        if (pop) loaded_q <= loaded_q + CNT_W'(1);
        overflow <= overflow | push_drop;
        if (pop && mis_nxt) mismatch <= 1'b1;
      end
      if (pop) begin
        vld_p1   <= 1'b1;
        addr_p1  <= addr_nxt;
        wdata_p1 <= wdata_nxt;
      end else if (acc) begin
        vld_p1 <= 1'b0;
      end
      for (int ch = 0; ch < SA_N; ch++) begin
        if (state == IDLE || fin) begin
          wr_ptr[ch] <= '0;
          rd_ptr[ch] <= '0;
        end else begin
          if (push_ok[ch]) wr_ptr[ch] <= wr_ptr[ch] + (PTR_W+1)'(1);
          if (pop)         rd_ptr[ch] <= rd_ptr[ch] + (PTR_W+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      base_q   <= base_addr;
      stride_q <= row_stride;
      npix_q   <= num_pixels;
    end
    for (int ch = 0; ch < SA_N; ch++)
      if (push_ok[ch]) fifo_p0[ch][wr_ptr[ch][PTR_W-1:0]] <= {in_row[ch], in_col[ch], in_data[ch]};
  end

  assign mem_wr_en = vld_p1;
  assign mem_addr  = addr_p1;
  assign mem_wdata = wdata_p1;
  assign busy      = (state == RUN);

endmodule

// File: tb/tb_requant_output_packer.sv
// Directed bench for requant_output_packer: basic tile, skew, backpressure, mismatch,
// corner cases and asynchronous reset mid-tile.
module tb_requant_output_packer;
  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [15:0]      base_addr, row_stride;
  logic [8:0]       num_pixels;
  logic [3:0]       in_valid;
  logic [3:0][3:0]  in_row, in_col;
  logic [3:0][7:0]  in_data;
  logic             mem_wr_en;
  logic [15:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_ready;
  logic             busy, done, mismatch;
  logic [3:0]       overflow;

  int errors = 0;
  int checks = 0;

  requant_output_packer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .row_stride(row_stride),
    .num_pixels(num_pixels), .in_valid(in_valid), .in_row(in_row), .in_col(in_col),
    .in_data(in_data), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .overflow(overflow), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] s, input logic [8:0] n);
    base_addr = b; row_stride = s; num_pixels = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [3:0] r, input logic [3:0] c, input logic [3:0] mask,
                      input logic [7:0] dbase);
    for (int ch = 0; ch < 4; ch++) begin
      in_row[ch]  = r;
      in_col[ch]  = c;
      in_data[ch] = dbase + 8'(ch);
    end
    in_valid = mask;
    tick();
    in_valid = '0;
  endtask

  logic [31:0] bp_word [5];

  initial begin
    bp_word[0] = 32'h03020100; bp_word[1] = 32'h13121110; bp_word[2] = 32'h23222120;
    bp_word[3] = 32'h33323130; bp_word[4] = 32'h43424140;
    reset = 1'b0; start = 1'b0; base_addr = '0; row_stride = '0; num_pixels = '0;
    in_valid = '0; in_row = '0; in_col = '0; in_data = '0; mem_ready = 1'b1;
    tick(); tick();
    chk("rst_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_mis", 32'(mismatch), 32'h0);
    reset = 1'b1;
    tick();

    // Basic tile
    do_start(16'h0100, 16'd4, 9'd4);
    chk("basic_busy", 32'(busy), 32'h1);
    push(4'd0, 4'd0, 4'hF, 8'h10);
    chk("basic_lat1", 32'(mem_wr_en), 32'h0);
    push(4'd0, 4'd1, 4'hF, 8'h10);
    chk("basic_wr0", 32'(mem_wr_en), 32'h1);
    chk("basic_addr0", 32'(mem_addr), 32'h0100);
    chk("basic_data0", mem_wdata, 32'h13121110);
    push(4'd1, 4'd0, 4'hF, 8'h10);
    chk("basic_addr1", 32'(mem_addr), 32'h0101);
    push(4'd1, 4'd1, 4'hF, 8'h10);
    chk("basic_addr2", 32'(mem_addr), 32'h0104);
    tick();
    chk("basic_addr3", 32'(mem_addr), 32'h0105);
    chk("basic_data3", mem_wdata, 32'h13121110);
    chk("basic_notdone", 32'(done), 32'h0);
    tick();
    chk("basic_done", 32'(done), 32'h1);
    chk("basic_busy_fall", 32'(busy), 32'h0);
    chk("basic_wr_off", 32'(mem_wr_en), 32'h0);
    tick();
    chk("basic_done_pulse", 32'(done), 32'h0);

    // Skewed channels
    do_start(16'h0000, 16'd4, 9'd1);
    push(4'd0, 4'd0, 4'h1, 8'h10);
    push(4'd0, 4'd0, 4'h2, 8'h10);
    push(4'd0, 4'd0, 4'h4, 8'h10);
    chk("skew_partial", 32'(mem_wr_en), 32'h0);
    push(4'd0, 4'd0, 4'h8, 8'h10);
    chk("skew_lat1", 32'(mem_wr_en), 32'h0);
    tick();
    chk("skew_wr", 32'(mem_wr_en), 32'h1);
    chk("skew_data", mem_wdata, 32'h13121110);
    chk("skew_mis", 32'(mismatch), 32'h0);
    tick();
    chk("skew_done", 32'(done), 32'h1);

    // Backpressure
    mem_ready = 1'b0;
    do_start(16'h0020, 16'd16, 9'd5);
    for (int i = 0; i < 6; i++) begin
      push(4'd0, 4'(i), 4'hF, 8'(i * 16));
      if (i == 4) chk("bp_ovf_before", 32'(overflow), 32'h0);
    end
    chk("bp_ovf", 32'(overflow), 32'hF);
    chk("bp_addr_hold", 32'(mem_addr), 32'h0020);
    chk("bp_data_hold", mem_wdata, bp_word[0]);
    for (int i = 0; i < 4; i++) tick();
    chk("bp_addr_hold2", 32'(mem_addr), 32'h0020);
    chk("bp_data_hold2", mem_wdata, bp_word[0]);
    chk("bp_wr_hold", 32'(mem_wr_en), 32'h1);
    mem_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("bp_addr", 32'(mem_addr), 32'h0020 + 32'(i));
      chk("bp_data", mem_wdata, bp_word[i]);
    end
    tick();
    chk("bp_done", 32'(done), 32'h1);
    chk("bp_wr_off", 32'(mem_wr_en), 32'h0);
    chk("bp_ovf_sticky", 32'(overflow), 32'hF);

    // Mismatch
    do_start(16'h0040, 16'd8, 9'd1);
    chk("start_clr_ovf", 32'(overflow), 32'h0);
    for (int ch = 0; ch < 4; ch++) begin
      in_row[ch] = 4'd0; in_col[ch] = 4'd0; in_data[ch] = 8'h10 + 8'(ch);
    end
    in_col[2] = 4'd1;
    in_valid = 4'hF;
    tick();
    in_valid = '0;
    tick();
    chk("mis_flag", 32'(mismatch), 32'h1);
    chk("mis_addr", 32'(mem_addr), 32'h0040);
    chk("mis_wr", 32'(mem_wr_en), 32'h1);
    tick();
    chk("mis_done", 32'(done), 32'h1);

    // num_pixels == 0
    do_start(16'h0000, 16'd4, 9'd0);
    chk("zero_busy", 32'(busy), 32'h1);
    chk("zero_mis_clr", 32'(mismatch), 32'h0);
    tick();
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_no_wr", 32'(mem_wr_en), 32'h0);
    tick();
    chk("zero_done_pulse", 32'(done), 32'h0);

    // start during RUN is ignored
    do_start(16'h0200, 16'd4, 9'd1);
    do_start(16'h0300, 16'd4, 9'd0);
    chk("rerun_busy", 32'(busy), 32'h1);
    tick();
    chk("rerun_no_done", 32'(done), 32'h0);
    push(4'd0, 4'd0, 4'hF, 8'h10);
    tick();
    chk("rerun_addr", 32'(mem_addr), 32'h0200);
    tick();
    chk("rerun_done", 32'(done), 32'h1);

    // Address wrap
    do_start(16'hFFFF, 16'd4, 9'd1);
    push(4'd0, 4'd1, 4'hF, 8'h10);
    tick();
    chk("wrap_addr", 32'(mem_addr), 32'h0000);
    chk("wrap_wr", 32'(mem_wr_en), 32'h1);
    tick();
    chk("wrap_done", 32'(done), 32'h1);

    // Reset mid-tile
    mem_ready = 1'b0;
    do_start(16'h0500, 16'd4, 9'd2);
    push(4'd0, 4'd0, 4'hF, 8'h10);
    push(4'd0, 4'd1, 4'hF, 8'h10);
    chk("mid_wr", 32'(mem_wr_en), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(mem_wr_en), 32'h0);
    chk("mid_rst_addr", 32'(mem_addr), 32'h0);
    chk("mid_rst_data", mem_wdata, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    tick();
    mem_ready = 1'b1;
    reset = 1'b1;
    tick();
    do_start(16'h0600, 16'd4, 9'd1);
    tick(); tick();
    chk("mid_fifo_empty", 32'(mem_wr_en), 32'h0);
    push(4'd1, 4'd2, 4'hF, 8'h20);
    tick();
    chk("mid_new_addr", 32'(mem_addr), 32'h0606);
    chk("mid_new_data", mem_wdata, 32'h23222120);
    tick();
    chk("mid_new_done", 32'(done), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/requant_output_packer.md
# requant_output_packer

Consumer side of the requantizer output interface. Accepts per-channel int8 results with (row, col) tags from the `SA_N` requantize channels. Buffers each channel in a small FIFO and aligns the channels for the same pixel. Packs the `SA_N` bytes into one channels-last word and writes it to activation memory through a valid/ready write port, then signals tile completion.

## Interface
- `SA_N`, 4: number of channels; also the number of bytes per memory word.
- `MAX_N`, 16: maximum tile rows/cols.
- `N_BITS`, `$clog2(MAX_N)`: width of the row/col tags.
- `ADDR_W`, 16: width of the memory word address.
- `FIFO_DEPTH`, 4: depth of each per-channel FIFO (power of 2).
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; latches the tile parameters. Honored only in IDLE.
- `base_addr`  in  `ADDR_W`  word address of pixel (0,0).
- `row_stride`  in  `ADDR_W`  words per output row.
- `num_pixels`  in  `2*N_BITS+1`  number of words to write for this tile.
- `in_valid`  in  `[SA_N]` x 1  per-channel data strobe. There is no ready; the upstream cannot stall.
- `in_row`, `in_col`  in  `[SA_N]` x `N_BITS`  pixel coordinates.
- `in_data`  in  `[SA_N]` x int8  requantized value.
- `mem_wr_en`  out  1  write request.
- `mem_addr`  out  `ADDR_W`  write address.
- `mem_wdata`  out  `8*SA_N`  packed word; channel ch occupies bits [8ch+7:8ch].
- `mem_ready`  in  1  write accepted when `mem_wr_en && mem_ready`.
- `busy`  out  1  high in RUN.
- `done`  out  1  single-cycle pulse when the tile completes.
- `overflow`  out  `SA_N`  sticky, per channel: data was dropped.
- `mismatch`  out  1  sticky: channel coordinates disagreed at a pop.

## Operation
- States:
  - IDLE: on `start`, latch the parameters, clear the pixel count, `overflow` and `mismatch`, and go to RUN.
  - RUN: when the count reaches `num_pixels` and no write is pending, pulse `done` and return to IDLE.
  - `start` in RUN is ignored.
  - `in_valid` in IDLE is ignored and is not flagged.
- FIFO push (RUN only):
  - `in_valid[ch]` pushes {`in_row`, `in_col`, `in_data`} into FIFO ch.
  - A push is accepted if the FIFO is not full, or if it is full and popping in the same cycle.
  - Otherwise the data is dropped and `overflow[ch]` is set.
- Pop: all `SA_N` FIFOs pop together when every FIFO is non-empty and the output register is empty or being accepted this cycle.
- Packing:
  - Channel ch byte goes to `mem_wdata[8ch+7:8ch]`.
  - Coordinates are taken from channel 0.
  - Any channel whose (row, col) differs from channel 0 sets `mismatch`; the word is still written.
- Address: `mem_addr = base_addr + row*row_stride + col`, computed in `ADDR_W` bits and wrapping modulo 2^`ADDR_W`.
- The pixel count increments on each accepted write (`mem_wr_en && mem_ready`).
- `num_pixels == 0`: go to RUN, then pulse `done` on the following cycle with no writes.
- FIFO data still queued when a tile completes is discarded on return to IDLE; the FIFO pointers reset.

## Timing
- Reset values: `mem_wr_en` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0, `done` 0, `overflow` 0, `mismatch` 0, state IDLE, FIFOs empty.
- Reset asserted mid-tile clears everything immediately; no write completes afterwards.
- `busy` rises in the cycle after the `start` edge.
- Latency: all channels valid at edge k into empty FIFOs, with the output register free → `mem_wr_en` high in the cycle following edge k+1. This is 2 edges.
- While `mem_wr_en && !mem_ready`:
  - `mem_addr` and `mem_wdata` are held stable.
  - No pop occurs.
- Sustained throughput is 1 word per cycle with `mem_ready` held high.
- `done` is asserted in the cycle after the edge that accepts the final write. `busy` falls in that same cycle.

## Test plan
- Basic tile:
  - Stimulus: `base_addr`=0x100, `row_stride`=4, `num_pixels`=4; all 4 channels valid together at (r,c) = (0,0), (0,1), (1,0), (1,1); data ch=0x10+ch.
  - Required response: writes to 0x100, 0x101, 0x104, 0x105 with word 0x13121110. `done` pulses once. Latency is 2 edges.
- Skewed channels:
  - Stimulus: ch0..ch3 valid for pixel (0,0) in cycles 0, 1, 2, 3.
  - Required response: a single write, issued 2 edges after ch3; `mismatch` stays 0.
- Backpressure:
  - Stimulus: `mem_ready`=0 for 10 cycles while all channels push 6 pixels.
  - Required response: `mem_addr`/`mem_wdata` stay stable; `overflow` = 4'b1111 after the 6th push (4 in the FIFO + 1 in the output register + 1 dropped). The remaining 5 words are written in order.
- Mismatch:
  - Stimulus: ch2 tagged (0,1) while the other channels are tagged (0,0).
  - Required response: `mismatch` = 1; the word is written at the channel 0 address.
- Edge cases:
  - `num_pixels`=0 → `done` pulse with no `mem_wr_en`.
  - `start` during RUN → ignored.
  - `base_addr`=0xFFFF, `col`=1 → `mem_addr` wraps to 0x0000.
- Reset mid-tile:
  - Stimulus: deassert `reset` (active-low) while `mem_wr_en` is high.
  - Required response: all outputs return to 0 immediately; a new `start` completes a fresh 1-pixel tile.
